// File: rtl/ram_access_unit.sv
// Load/store controller in front of the byte-lane data RAM: one request at a time,
// registered RAM pins, 1-cycle read latency absorbed. Optional macro RAU_MISALIGN_CHK_EN.
module ram_access_unit #(
  parameter logic [31:0] MEM_SIZE_BYTES = 32'h0002_0000,
  parameter int          ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic              resp_err,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [3:0]        ram_sel_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [31:0]       ram_data_o,
  input  logic [31:0]       ram_data_i
);

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LBU = 3'b001;
  localparam logic [2:0] OP_LH  = 3'b010;
  localparam logic [2:0] OP_LHU = 3'b011;
  localparam logic [2:0] OP_LW  = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SW  = 3'b111;

  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_SIZE_BYTES);

  typedef enum logic [1:0] {IDLE, ACCESS, LOAD_CAP, RESP} state_t;

  state_t            state;
  logic [2:0]        op_q;
  logic [1:0]        off_q;

  logic              is_half, is_word, is_store;
  logic              misaligned, out_of_range;
  logic [ADDR_W-1:0] addr_eff;
  logic [3:0]        sel_nxt;
  logic [31:0]       data_nxt;

  always_comb begin
    is_half  = (req_op == OP_LH) || (req_op == OP_LHU) || (req_op == OP_SH);
    is_word  = (req_op == OP_LW) || (req_op == OP_SW);
    is_store = (req_op == OP_SB) || (req_op == OP_SH) || (req_op == OP_SW);
    addr_eff = req_addr;
`ifdef RAU_MISALIGN_CHK_EN
    misaligned = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
`else
    // Without the check, sub-word misalignment is silently rounded down.
    misaligned = 1'b0;
    if (is_half) addr_eff[0] = 1'b0;
    if (is_word) addr_eff[1:0] = 2'b00;
`endif
    out_of_range = {1'b0, req_addr} >= MEM_LIMIT;

    sel_nxt  = 4'b1111;
    data_nxt = req_wdata;
    case (req_op)
      OP_SB: begin
        sel_nxt  = 4'b1000 >> addr_eff[1:0];
        data_nxt = {4{req_wdata[7:0]}};
      end
      OP_SH: begin
        sel_nxt  = addr_eff[1] ? 4'b0011 : 4'b1100;
        data_nxt = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  logic [31:0] word_be;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_res;

  // RAM returns lanes reversed; rebuild so bits [31:24] are byte offset 0.
  always_comb begin
    word_be = {ram_data_i[7:0], ram_data_i[15:8], ram_data_i[23:16], ram_data_i[31:24]};
    case (off_q)
      2'd0:    byte_sel = word_be[31:24];
      2'd1:    byte_sel = word_be[23:16];
      2'd2:    byte_sel = word_be[15:8];
      default: byte_sel = word_be[7:0];
    endcase
    half_sel = off_q[1] ? word_be[15:0] : word_be[31:16];
    case (op_q)
      OP_LB:   load_res = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_res = {24'h0, byte_sel};
      OP_LH:   load_res = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_res = {16'h0, half_sel};
      default: load_res = word_be;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= OP_LB;
      off_q      <= 2'b00;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_data  <= 32'h0;
      ram_ce_o   <= 1'b0;
      ram_we_o   <= 1'b0;
      ram_sel_o  <= 4'b0000;
      ram_addr_o <= '0;
      ram_data_o <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q      <= req_op;
            off_q     <= addr_eff[1:0];
            req_ready <= 1'b0;
            if (misaligned || out_of_range) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_data  <= 32'h0;
            end else begin
              state      <= ACCESS;
              ram_ce_o   <= 1'b1;
              ram_we_o   <= is_store;
              ram_sel_o  <= sel_nxt;
              ram_addr_o <= {addr_eff[ADDR_W-1:2], 2'b00};
              ram_data_o <= data_nxt;
            end
          end
        end
        ACCESS: begin
          ram_ce_o <= 1'b0;
          ram_we_o <= 1'b0;
          if (op_q == OP_SB || op_q == OP_SH || op_q == OP_SW) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_data  <= 32'h0;
          end else begin
            state <= LOAD_CAP;
          end
        end
        LOAD_CAP: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_data  <= load_res;
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_unit.sv
// Bench for ram_access_unit: byte-level memory model, per-cycle compare process,
// RAM behavioural model with 1-cycle read latency and reversed read lanes.
module tb_ram_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        ram_ce_o, ram_we_o;
  logic [3:0]  ram_sel_o;
  logic [31:0] ram_addr_o, ram_data_o;
  logic [31:0] ram_data_i = 32'h0;

  ram_access_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_sel_o(ram_sel_o),
    .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: word store in big-endian orientation, [31:24] = offset 0.
  logic [31:0] ram_w [logic [29:0]];
  logic [31:0] rw;
  always @(posedge clk) begin
    if (ram_ce_o) begin
      rw = ram_w.exists(ram_addr_o[31:2]) ? ram_w[ram_addr_o[31:2]] : 32'h0;
      if (ram_we_o) begin
        for (int i = 0; i < 4; i++)
          if (ram_sel_o[i]) rw[8*i +: 8] = ram_data_o[8*i +: 8];
        ram_w[ram_addr_o[31:2]] = rw;
      end else begin
        ram_data_i <= {rw[7:0], rw[15:8], rw[23:16], rw[31:24]};
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Reference model: flat byte memory, big-endian.
  logic [7:0] mem_b [logic [31:0]];
  function automatic logic [7:0] rdb(input logic [31:0] a);
    return mem_b.exists(a) ? mem_b[a] : 8'h00;
  endfunction

  bit          active = 0;
  int          acc_c, resp_c, end_c;
  logic [31:0] e_data, e_addr, e_wd;
  logic        e_err, e_store;
  logic [3:0]  e_sel;

  always @(negedge clk) begin
    if (active && cyc >= acc_c && cyc <= end_c) begin
      check("ram_ce", {31'h0, ram_ce_o}, {31'h0, (!e_err && cyc == acc_c)});
      if (!e_err && cyc == acc_c) begin
        check("ram_we", {31'h0, ram_we_o}, {31'h0, e_store});
        check("ram_sel", {28'h0, ram_sel_o}, {28'h0, e_sel});
        check("ram_addr", ram_addr_o, e_addr);
        if (e_store) check("ram_data", ram_data_o, e_wd);
      end
      if (cyc < resp_c) begin
        check("resp_valid_early", {31'h0, resp_valid}, 32'h0);
        check("req_ready_busy", {31'h0, req_ready}, 32'h0);
      end else if (cyc < end_c) begin
        check("resp_valid", {31'h0, resp_valid}, 32'h1);
        check("resp_data", resp_data, e_data);
        check("resp_err", {31'h0, resp_err}, {31'h0, e_err});
        check("req_ready_resp", {31'h0, req_ready}, 32'h0);
      end else begin
        check("resp_valid_done", {31'h0, resp_valid}, 32'h0);
        check("req_ready_done", {31'h0, req_ready}, 32'h1);
      end
    end
  end

  task automatic wait_ready(output bit ok);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = req_ready;
    if (!ok) check("ready_timeout", 32'h0, 32'h1);
  endtask

  task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input int stall, input bit pin, input logic [31:0] lit, input bit lit_err);
    bit ok;
    logic [31:0] a;
    bit half, word, mis;
    logic [7:0] b;
    logic [15:0] h;
    int lat;
    wait_ready(ok);
    if (!ok) return;
    a    = addr;
    half = (op == 3'd2) || (op == 3'd3) || (op == 3'd6);
    word = (op == 3'd4) || (op == 3'd7);
`ifdef RAU_MISALIGN_CHK_EN
    mis = (half && a[0]) || (word && a[1:0] != 2'b00);
`else
    mis = 0;
    if (half) a[0] = 1'b0;
    if (word) a[1:0] = 2'b00;
`endif
    e_err   = mis || (addr >= 32'h0002_0000);
    e_store = (op >= 3'd5);
    e_addr  = {a[31:2], 2'b00};
    b = rdb(a);
    h = {rdb(a), rdb(a + 1)};
    e_data = 32'h0;
    if (!e_err && !e_store) begin
      case (op)
        3'd0: e_data = {{24{b[7]}}, b};
        3'd1: e_data = {24'h0, b};
        3'd2: e_data = {{16{h[15]}}, h};
        3'd3: e_data = {16'h0, h};
        default: e_data = {rdb(a), rdb(a + 1), rdb(a + 2), rdb(a + 3)};
      endcase
    end
    case (op)
      3'd5: begin e_sel = 4'b1000 >> a[1:0]; e_wd = {4{wd[7:0]}}; end
      3'd6: begin e_sel = a[1] ? 4'b0011 : 4'b1100; e_wd = {2{wd[15:0]}}; end
      default: begin e_sel = 4'b1111; e_wd = wd; end
    endcase
    if (e_store && !e_err) begin
      if (op == 3'd5) mem_b[a] = wd[7:0];
      else if (op == 3'd6) begin mem_b[a] = wd[15:8]; mem_b[a + 1] = wd[7:0]; end
      else for (int i = 0; i < 4; i++) mem_b[a + i] = wd[31 - 8*i -: 8];
    end
    if (pin) begin
      check("model_data", e_data, lit);
      check("model_err", {31'h0, e_err}, {31'h0, lit_err});
    end
    lat    = e_err ? 1 : (e_store ? 2 : 3);
    acc_c  = cyc + 1;
    resp_c = acc_c + lat - 1;
    end_c  = resp_c + stall + 1;
    active = 1;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    while (cyc < resp_c + stall) @(negedge clk);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    @(negedge clk);
    active = 0;
  endtask

  task automatic reset_mid_load();
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    req_valid = 1'b1; req_op = 3'd4; req_addr = 32'h100; req_wdata = 32'h0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rst_access_ce", {31'h0, ram_ce_o}, 32'h1);
    @(negedge clk);
    check("rst_loadcap_ce", {31'h0, ram_ce_o}, 32'h0);
    check("rst_loadcap_valid", {31'h0, resp_valid}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_ce", {31'h0, ram_ce_o}, 32'h0);
    check("rst_data", resp_data, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_no_resp", {31'h0, resp_valid}, 32'h0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", {31'h0, req_ready}, 32'h1);
    check("reset_valid", {31'h0, resp_valid}, 32'h0);
    check("reset_err", {31'h0, resp_err}, 32'h0);
    check("reset_data", resp_data, 32'h0);
    check("reset_ce", {31'h0, ram_ce_o}, 32'h0);
    check("reset_we", {31'h0, ram_we_o}, 32'h0);
    check("reset_sel", {28'h0, ram_sel_o}, 32'h0);
    check("reset_addr", ram_addr_o, 32'h0);
    check("reset_wdata", ram_data_o, 32'h0);
    rst = 1'b0;

    do_req(3'd7, 32'h100, 32'h11223344, 0, 1, 32'h0, 0);
    do_req(3'd4, 32'h100, 32'h0, 0, 1, 32'h11223344, 0);
    do_req(3'd5, 32'h103, 32'h80, 0, 1, 32'h0, 0);
    do_req(3'd0, 32'h103, 32'h0, 0, 1, 32'hFFFFFF80, 0);
    do_req(3'd1, 32'h103, 32'h0, 0, 1, 32'h00000080, 0);
    do_req(3'd0, 32'h101, 32'h0, 0, 1, 32'h00000022, 0);
    do_req(3'd6, 32'h202, 32'h0000BEEF, 0, 1, 32'h0, 0);
    do_req(3'd2, 32'h202, 32'h0, 0, 1, 32'hFFFFBEEF, 0);
    do_req(3'd3, 32'h202, 32'h0, 0, 1, 32'h0000BEEF, 0);
`ifdef RAU_MISALIGN_CHK_EN
    do_req(3'd2, 32'h101, 32'h0, 0, 1, 32'h0, 1);
    do_req(3'd7, 32'h102, 32'hDEADBEEF, 0, 1, 32'h0, 1);
`else
    do_req(3'd2, 32'h101, 32'h0, 0, 1, 32'h00001122, 0);
    do_req(3'd7, 32'h302, 32'hDEADBEEF, 0, 1, 32'h0, 0);
    do_req(3'd4, 32'h300, 32'h0, 0, 1, 32'hDEADBEEF, 0);
`endif
    do_req(3'd4, 32'h0002_0000, 32'h0, 0, 1, 32'h0, 1);
    do_req(3'd7, 32'h0002_0004, 32'h12345678, 0, 1, 32'h0, 1);
    do_req(3'd4, 32'h100, 32'h0, 5, 1, 32'h11223380, 0);
    do_req(3'd5, 32'h0001_FFFF, 32'h7F, 0, 1, 32'h0, 0);
    do_req(3'd0, 32'h0001_FFFF, 32'h0, 0, 1, 32'h0000007F, 0);
    do_req(3'd3, 32'h0001_FFFE, 32'h0, 2, 1, 32'h0000007F, 0);
    do_req(3'd0, 32'h0000_0400, 32'h0, 0, 1, 32'h0, 0);
    reset_mid_load();
    do_req(3'd4, 32'h0001_FFFC, 32'h0, 0, 1, 32'h0000007F, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ram_access_unit.md
Name: ram_access_unit

Overview:
- Load/store access controller sitting directly upstream of the byte-lane data RAM.
- Accepts one load/store request at a time from the MEM stage, drives the RAM control, address, lane-select and write-data pins, and absorbs the RAM's 1-cycle synchronous read latency.
- Returns the extracted, sign- or zero-extended load result, or a store completion, through a valid/ready response port.
- Big-endian byte numbering: byte offset 0 is the most-significant lane.

Parameters:
- MEM_SIZE_BYTES, 32'h0002_0000 — size of the data RAM in bytes. An address >= this value is out of range.
- ADDR_W, 32 — width of the request address and ram_addr_o.

Ports:
- clk  in  1  — single clock.
- rst  in  1  — synchronous, active-high reset.
- req_valid  in  1  — request present.
- req_ready  out  1  — unit can accept a request.
- req_op  in  3  — 000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, 101 SB, 110 SH, 111 SW.
- req_addr  in  ADDR_W  — byte address.
- req_wdata  in  32  — store data, right-justified.
- resp_valid  out  1  — response present.
- resp_ready  in  1  — consumer takes the response.
- resp_data  out  32  — load result; 0 for stores and errors.
- resp_err  out  1  — misaligned or out-of-range access.
- ram_ce_o  out  1  — RAM chip enable (1 = enable).
- ram_we_o  out  1  — RAM write enable (1 = write).
- ram_sel_o  out  4  — lane select. sel[3] = offset 0 = data[31:24]; sel[0] = offset 3 = data[7:0].
- ram_addr_o  out  ADDR_W  — word-aligned byte address; low 2 bits = 0.
- ram_data_o  out  32  — RAM write data.
- ram_data_i  in  32  — RAM read data, valid the cycle after the RAM samples a read. Lanes arrive reversed: [7:0] = offset 0, [15:8] = offset 1, [23:16] = offset 2, [31:24] = offset 3.

Behaviour:
- All outputs are registered.
- Reset values: req_ready=1, resp_valid=0, resp_err=0, resp_data=0, ram_ce_o=0, ram_we_o=0, ram_sel_o=0, ram_addr_o=0, ram_data_o=0.
- States: IDLE, ACCESS, LOAD_CAP, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at the clock edge, capture op, addr and wdata; req_ready drops next cycle.
  - Misaligned (halfword with addr[0]=1, word with addr[1:0]!=0) or addr >= MEM_SIZE_BYTES: go to RESP with resp_err=1, resp_data=0. No RAM access is made (ram_ce_o stays 0).
  - Otherwise go to ACCESS.
- ACCESS:
  - Exactly one cycle with ram_ce_o=1.
  - ram_we_o=1 for stores, 0 for loads.
  - ram_addr_o = {addr[ADDR_W-1:2], 2'b00}.
  - Stores:
    - SB: data = {4{wdata[7:0]}}, sel = 4'b1000 >> addr[1:0].
    - SH: data = {2{wdata[15:0]}}, sel = 1100 when addr[1]=0, 0011 when addr[1]=1.
    - SW: data = wdata, sel = 1111.
  - Loads drive sel=1111.
  - Next state: stores go to RESP; loads go to LOAD_CAP.
- LOAD_CAP:
  - ram_ce_o=0.
  - Rebuild W = {ram_data_i[7:0], ram_data_i[15:8], ram_data_i[23:16], ram_data_i[31:24]}.
  - Select the byte or halfword at the captured offset from W; LB and LH sign-extend, LBU and LHU zero-extend.
  - Register the result into resp_data; go to RESP.
- RESP:
  - resp_valid=1; resp_data and resp_err held stable until resp_ready=1.
  - On the handshake edge: resp_valid=0, resp_err=0, return to IDLE.
  - The next request is accepted no earlier than the following cycle (no bypass).
- Latency from the accept edge to resp_valid high:
  - load: 3 cycles;
  - store: 2 cycles;
  - error: 1 cycle.
- resp_data is 0 for stores.
- Reset mid-operation: next cycle forced to IDLE with reset values. Any pending response is dropped. A store whose ACCESS cycle already completed stays written.
- req_valid while not in IDLE is ignored; the requester holds the request.

Optional Feature:
- Macro: RAU_MISALIGN_CHK_EN.
- Defined: misaligned accesses return resp_err=1, as described above.
- Undefined:
  - The alignment check is removed.
  - The address is forced aligned: bit 0 cleared for halfword ops, bits [1:0] cleared for word ops.
  - The access proceeds normally. resp_err is raised only for out-of-range addresses.

Test Plan:
- SW 0x100 wdata 0x11223344 → ACCESS cycle with sel=1111, ram_data_o=0x11223344, ram_addr_o=0x100; resp_valid 2 cycles after accept. Then LW 0x100 → resp_data=0x11223344 3 cycles after accept.
- SB 0x103 wdata 0x80 → sel=0001, ram_data_o=0x80808080. Then LB 0x103 → 0xFFFFFF80; LBU 0x103 → 0x00000080; LB 0x101 (after the SW above) → 0x00000022.
- SH 0x202 wdata 0x0000BEEF → sel=0011. Then LH 0x202 → 0xFFFFBEEF; LHU 0x202 → 0x0000BEEF.
- LH 0x101 with the macro defined → resp_err=1, resp_data=0 one cycle after accept, ram_ce_o never 1. With the macro undefined → access at 0x100, resp_err=0. LW 0x0002_0000 → resp_err=1 in both builds.
- LW with resp_ready held 0 for 5 cycles → resp_valid and resp_data stable throughout, req_ready=0; on resp_ready=1, return to IDLE.
- rst asserted in LOAD_CAP → next cycle resp_valid=0, req_ready=1, ram_ce_o=0; no response is ever issued.
